// File: rtl/al_pkg.sv
// Shared definitions for the wide-to-narrow handshake aligner:
// FSM state encoding and parameter legality helpers.
package al_pkg;

    typedef enum logic {
        AL_EMPTY = 1'b0,
        AL_BUSY  = 1'b1
    } al_state_e;

    // Legal when the wide word splits evenly into at least two slices.
    function automatic bit al_params_ok(input int unsigned in_w, input int unsigned out_w);
        if (out_w == 0) return 1'b0;
        return ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

    function automatic int unsigned al_sel_w(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/cnt_cfg_lim.sv
// Wrapping counter with a runtime limit: counts 0..lim on inc, then wraps
// to zero; clr has priority.
module cnt_cfg_lim #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            // >= keeps the counter bounded even if lim shrinks under it
            cnt_d = (cnt_q >= lim) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/al_w2n_hs.sv
// Wide-to-narrow width converter with valid/ready on both sides: holds one
// wide beat and emits its valid slices LSB first, reloading without a bubble.
module al_w2n_hs
    import al_pkg::*;
#(
    parameter int unsigned DAT_IN_W  = 32,
    parameter int unsigned DAT_OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 us_vld,
    output logic                 us_rdy,
    input  logic [DAT_IN_W-1:0]  us_dat,
    input  logic [al_sel_w(DAT_IN_W/DAT_OUT_W)-1:0] us_last_vld_sel,
    input  logic                 us_eop,
    output logic                 ds_vld,
    input  logic                 ds_rdy,
    output logic [DAT_OUT_W-1:0] ds_dat,
    output logic                 ds_eop,
    output logic [al_sel_w(DAT_IN_W/DAT_OUT_W)-1:0] ds_idx
);

    localparam int unsigned RATIO = DAT_IN_W / DAT_OUT_W;
    localparam int unsigned SEL_W = al_sel_w(RATIO);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(RATIO - 1);

    if (!al_params_ok(DAT_IN_W, DAT_OUT_W)) begin : g_bad_params
        $fatal(1, "al_w2n_hs: DAT_IN_W must be a multiple (>=2x) of DAT_OUT_W");
    end

    al_state_e           state_d,    state_q;
    logic [DAT_IN_W-1:0] hold_dat_d, hold_dat_q;
    logic [SEL_W-1:0]    hold_sel_d, hold_sel_q;
    logic                hold_eop_d, hold_eop_q;

    logic                 hold_full;
    logic                 last_slice;
    logic                 us_xfer;
    logic                 ds_xfer;
    logic                 load;
    logic [SEL_W-1:0]     cnt;
    logic [DAT_OUT_W-1:0] slice_arr [RATIO];

    assign hold_full  = (state_q == AL_BUSY);
    assign last_slice = (cnt == hold_sel_q);
    assign us_rdy     = ~hold_full | (ds_rdy & last_slice);
    assign us_xfer    = us_vld & us_rdy;
    assign ds_xfer    = ds_vld & ds_rdy;

    always_comb begin
        for (int unsigned i = 0; i < RATIO; i++) begin
            slice_arr[i] = hold_dat_q[i*DAT_OUT_W +: DAT_OUT_W];
        end
    end

    assign ds_vld = hold_full;
    assign ds_dat = slice_arr[cnt];
    assign ds_idx = cnt;
    assign ds_eop = hold_full & hold_eop_q & last_slice;

    always_comb begin
        state_d    = state_q;
        hold_dat_d = hold_dat_q;
        hold_sel_d = hold_sel_q;
        hold_eop_d = hold_eop_q;
        load       = 1'b0;
        unique case (state_q)
            AL_EMPTY: begin
                if (us_xfer) begin
                    load    = 1'b1;
                    state_d = AL_BUSY;
                end
            end
            AL_BUSY: begin
                if (ds_xfer && last_slice) begin
                    if (us_xfer) load    = 1'b1;
                    else         state_d = AL_EMPTY;
                end
            end
            default: state_d = AL_EMPTY;
        endcase
        if (load) begin
            hold_dat_d = us_dat;
            hold_sel_d = (us_last_vld_sel > SEL_MAX) ? SEL_MAX : us_last_vld_sel;
            hold_eop_d = us_eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AL_EMPTY;
            hold_dat_q <= '0;
            hold_sel_q <= '0;
            hold_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_dat_q <= hold_dat_d;
            hold_sel_q <= hold_sel_d;
            hold_eop_q <= hold_eop_d;
        end
    end

    // A reload while busy coincides with the wrap at last_slice; clr makes
    // the restart at slice 0 explicit rather than relying on that wrap.
    cnt_cfg_lim #(
        .W (SEL_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load & hold_full),
        .inc   (ds_xfer),
        .lim   (hold_sel_q),
        .cnt   (cnt)
    );

endmodule
